// File: rtl/vc_noc_pkg.sv
// Shared NoC definitions: flit geometry, flit type codes and arbiter state encoding.
package vc_noc_pkg;

    localparam int FLIT_W    = 34;
    localparam int N_VC_MAX  = 4;
    localparam int VC_ID_W   = 2;
    localparam int FTYPE_LSB = FLIT_W - 2;

    localparam logic [1:0] HEAD_FLIT = 2'b00;
    localparam logic [1:0] BODY_FLIT = 2'b01;
    localparam logic [1:0] TAIL_FLIT = 2'b11;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    function automatic logic [1:0] flit_type(input logic [FLIT_W-1:0] flit);
        return flit[FTYPE_LSB +: 2];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins (one-hot grant).
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    // Scan from farthest to nearest so the requester closest to ptr overwrites the rest.
    always_comb begin
        int idx;
        grant = '0;
        idx   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_out_arbiter.sv
// Wormhole VC output arbiter: locks one VC head-to-tail onto a registered flit stream.
// Optional build macro VC_OUT_FIXED_PRIO_EN selects fixed priority (highest VC wins) instead of round-robin.
module vc_out_arbiter
    import vc_noc_pkg::*;
#(
    parameter int N_VC   = 4,
    parameter int FLIT_W = 34
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [N_VC*FLIT_W-1:0] fdata_i,
    input  logic [N_VC-1:0]        valid_i,
    output logic [N_VC-1:0]        ready_o,
    output logic [FLIT_W-1:0]      fdata_o,
    output logic [VC_ID_W-1:0]     vc_id_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   proto_err_o
);

    arb_state_e         state;
    logic [VC_ID_W-1:0] lock_vc;
    logic [VC_ID_W-1:0] win_id;
    logic [VC_ID_W-1:0] sel_vc;
    logic [N_VC-1:0]    head_req;
    logic [N_VC-1:0]    grant;
    logic [N_VC-1:0]    drop_sel;
    logic [N_VC-1:0]    ready_c;
    logic [FLIT_W-1:0]  sel_flit;
    logic [1:0]         sel_type;
    logic               out_free;
    logic               any_head;
    logic               accept;

    assign out_free = !valid_o || ready_i;
    assign any_head = |head_req;

    always_comb begin
        head_req = '0;
        for (int k = 0; k < N_VC; k++)
            head_req[k] = valid_i[k] && (flit_type(fdata_i[k*FLIT_W +: FLIT_W]) == HEAD_FLIT);
    end

`ifdef VC_OUT_FIXED_PRIO_EN
    always_comb begin
        grant = '0;
        for (int k = 0; k < N_VC; k++) begin
            if (head_req[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
            end
        end
    end
`else
    logic [VC_ID_W-1:0] rr_ptr;

    rr_arbiter #(
        .N     (N_VC),
        .PTR_W (VC_ID_W)
    ) u_rr (
        .req   (head_req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Pointer moves past the winner only when a head is actually taken.
    always_ff @(posedge clk) begin
        if (arst)
            rr_ptr <= '0;
        else if (state == ARB_IDLE && any_head && out_free)
            rr_ptr <= (win_id == VC_ID_W'(N_VC - 1)) ? '0 : win_id + 1'b1;
    end
`endif

    always_comb begin
        win_id = '0;
        for (int k = 0; k < N_VC; k++)
            if (grant[k]) win_id = VC_ID_W'(k);
    end

    // With no head on offer, any valid flit is orphaned; swallow the lowest one.
    always_comb begin
        drop_sel = '0;
        if (state == ARB_IDLE && !any_head) begin
            for (int k = N_VC - 1; k >= 0; k--) begin
                if (valid_i[k]) begin
                    drop_sel    = '0;
                    drop_sel[k] = 1'b1;
                end
            end
        end
    end

    assign sel_vc   = (state == ARB_IDLE) ? win_id : lock_vc;
    assign sel_flit = fdata_i[sel_vc*FLIT_W +: FLIT_W];
    assign sel_type = flit_type(sel_flit);

    always_comb begin
        ready_c = drop_sel;
        if (state == ARB_IDLE) begin
            if (out_free) ready_c = ready_c | grant;
        end else begin
            ready_c[lock_vc] = out_free;
        end
    end

    assign ready_o = arst ? '0 : ready_c;
    assign accept  = |(valid_i & ready_c & ~drop_sel);

    always_ff @(posedge clk) begin
        if (arst) begin
            state       <= ARB_IDLE;
            lock_vc     <= '0;
            fdata_o     <= '0;
            vc_id_o     <= '0;
            valid_o     <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            if (accept) begin
                fdata_o <= sel_flit;
                vc_id_o <= sel_vc;
                valid_o <= 1'b1;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
            if (|drop_sel) proto_err_o <= 1'b1;
            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        state   <= ARB_LOCKED;
                        lock_vc <= win_id;
                    end
                end
                ARB_LOCKED: begin
                    if (accept) begin
                        if (sel_type == TAIL_FLIT)
                            state <= ARB_IDLE;
                        else if (sel_type == HEAD_FLIT)
                            proto_err_o <= 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vc_out_arbiter.sv
// Bench for vc_out_arbiter: directed packet scenarios plus randomized multi-VC traffic vs. a behavioural model.
module tb_vc_out_arbiter;
    import vc_noc_pkg::*;

    localparam int NV = 4;
    localparam int FW = 34;

    logic              clk = 1'b0;
    logic              arst;
    logic [NV*FW-1:0]  fdata_i;
    logic [NV-1:0]     valid_i;
    logic [NV-1:0]     ready_o;
    logic [FW-1:0]     fdata_o;
    logic [1:0]        vc_id_o;
    logic              valid_o;
    logic              ready_i;
    logic              proto_err_o;

    always #5 clk = ~clk;

    vc_out_arbiter #(.N_VC(NV), .FLIT_W(FW)) dut (
        .clk         (clk),
        .arst        (arst),
        .fdata_i     (fdata_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .fdata_o     (fdata_o),
        .vc_id_o     (vc_id_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .proto_err_o (proto_err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the output, where round-robin resumes, and what the output register holds.
    bit            m_locked;
    int            m_lock_vc;
    int            m_ptr;
    bit            m_valid;
    logic [FW-1:0] m_data;
    int            m_vc;
    bit            m_err;

    logic [NV-1:0] last_ready;
    logic [NV-1:0] acc_mask;
    logic [FW-1:0] srcq [NV][$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] fl(input logic [1:0] t, input logic [31:0] p);
        return {t, p};
    endfunction

    function automatic logic [NV*FW-1:0] pk(input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                                           input logic [FW-1:0] f2, input logic [FW-1:0] f3);
        return {f3, f2, f1, f0};
    endfunction

    task automatic model_reset();
        m_locked  = 0;
        m_lock_vc = 0;
        m_ptr     = 0;
        m_valid   = 0;
        m_data    = '0;
        m_vc      = 0;
        m_err     = 0;
    endtask

    // Which VC the rules say is accepted this cycle, and whether it is an orphan drop.
    task automatic model_ready(input logic [NV-1:0] v, input logic [NV*FW-1:0] d, input logic rdy,
                               output logic [NV-1:0] r, output int fwd, output bit drop);
        bit            space;
        int            win;
        logic [FW-1:0] f;
        r     = '0;
        fwd   = -1;
        drop  = 0;
        space = !m_valid || rdy;
        if (m_locked) begin
            if (space) r[m_lock_vc] = 1'b1;
            if (space && v[m_lock_vc]) fwd = m_lock_vc;
        end else begin
            win = -1;
`ifdef VC_OUT_FIXED_PRIO_EN
            for (int i = 0; i < NV; i++) begin
                f = d[i*FW +: FW];
                if (v[i] && f[FW-1 -: 2] == HEAD_FLIT) win = i;
            end
`else
            for (int i = 0; i < NV && win < 0; i++) begin
                f = d[((m_ptr + i) % NV)*FW +: FW];
                if (v[(m_ptr + i) % NV] && f[FW-1 -: 2] == HEAD_FLIT) win = (m_ptr + i) % NV;
            end
`endif
            if (win >= 0) begin
                if (space) begin
                    r[win] = 1'b1;
                    fwd    = win;
                end
            end else begin
                for (int i = 0; i < NV && !drop; i++) begin
                    if (v[i]) begin
                        r[i] = 1'b1;
                        drop = 1;
                    end
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, check registered outputs and ready_o, advance the model.
    task automatic cycle(input logic [NV-1:0] v, input logic [NV*FW-1:0] d, input logic rdy, input logic rst);
        logic [NV-1:0] er;
        int            fwd;
        bit            drop;
        logic [FW-1:0] f;
        @(negedge clk);
        valid_i = v;
        fdata_i = d;
        ready_i = rdy;
        arst    = rst;
        #1;
        chk("valid_o", 64'(valid_o), 64'(m_valid));
        chk("fdata_o", 64'(fdata_o), 64'(m_data));
        chk("vc_id_o", 64'(vc_id_o), 64'(m_vc));
        chk("proto_err_o", 64'(proto_err_o), 64'(m_err));
        if (rst) begin
            er   = '0;
            fwd  = -1;
            drop = 0;
        end else begin
            model_ready(v, d, rdy, er, fwd, drop);
        end
        last_ready = ready_o;
        chk("ready_o", 64'(ready_o), 64'(er));
        acc_mask = v & er;
        if (rst) begin
            model_reset();
        end else begin
            if (fwd >= 0) begin
                f = d[fwd*FW +: FW];
                if (!m_locked) begin
                    m_locked  = 1;
                    m_lock_vc = fwd;
                    m_ptr     = (fwd + 1) % NV;
                end else if (f[FW-1 -: 2] == TAIL_FLIT) begin
                    m_locked = 0;
                end else if (f[FW-1 -: 2] == HEAD_FLIT) begin
                    m_err = 1;
                end
                m_data  = f;
                m_vc    = fwd;
                m_valid = 1;
            end else if (rdy) begin
                m_valid = 0;
            end
            if (drop) m_err = 1;
        end
        @(posedge clk);
    endtask

    task automatic reset_dut();
        cycle(4'b1111, pk(fl(HEAD_FLIT, 32'h1), fl(HEAD_FLIT, 32'h2), fl(HEAD_FLIT, 32'h3), fl(HEAD_FLIT, 32'h4)), 1'b1, 1'b1);
        chk("rst_ready", 64'(last_ready), 64'h0);
        cycle('0, '0, 1'b1, 1'b1);
        #1;
        chk("rst_valid", 64'(valid_o), 64'h0);
        chk("rst_fdata", 64'(fdata_o), 64'h0);
        chk("rst_vc", 64'(vc_id_o), 64'h0);
        chk("rst_err", 64'(proto_err_o), 64'h0);
    endtask

    task automatic refill(input int k);
        int            r;
        int            nb;
        logic [1:0]    t;
        r = $urandom_range(0, 15);
        if (r == 0) begin
            srcq[k].push_back(fl(BODY_FLIT, $urandom));
        end else if (r == 1) begin
            srcq[k].push_back(fl(TAIL_FLIT, $urandom));
        end else begin
            srcq[k].push_back(fl(HEAD_FLIT, $urandom));
            nb = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) begin
                t = ($urandom_range(0, 3) == 0) ? 2'b10 : BODY_FLIT;
                if ($urandom_range(0, 19) == 0) t = HEAD_FLIT;
                srcq[k].push_back(fl(t, $urandom));
            end
            srcq[k].push_back(fl(TAIL_FLIT, $urandom));
        end
    endtask

    initial begin
        logic [FW-1:0]    h, b, t, ha, ba, ta, hc, tc, hd, td;
        logic [NV-1:0]    v;
        logic [NV*FW-1:0] d;
        logic             rdy;
        logic             rst;

        model_reset();
        arst    = 1'b1;
        valid_i = '0;
        fdata_i = '0;
        ready_i = 1'b1;
        repeat (2) @(posedge clk);

        reset_dut();

`ifndef VC_OUT_FIXED_PRIO_EN
        // Single packet on VC1.
        h = fl(HEAD_FLIT, 32'hA1); b = fl(BODY_FLIT, 32'hB1); t = fl(TAIL_FLIT, 32'hC1);
        cycle(4'b0010, pk('0, h, '0, '0), 1'b1, 1'b0);
        chk("t1_rdy_h", 64'(last_ready), 64'h2);
        #1; chk("t1_out_h", 64'(fdata_o), 64'(h)); chk("t1_vc", 64'(vc_id_o), 64'h1);
        cycle(4'b0010, pk('0, b, '0, '0), 1'b1, 1'b0);
        #1; chk("t1_out_b", 64'(fdata_o), 64'(b));
        cycle(4'b0010, pk('0, t, '0, '0), 1'b1, 1'b0);
        #1; chk("t1_out_t", 64'(fdata_o), 64'(t)); chk("t1_valid_t", 64'(valid_o), 64'h1);
        cycle('0, '0, 1'b1, 1'b0);
        #1; chk("t1_valid_end", 64'(valid_o), 64'h0);

        // VC0 and VC2 heads together, pointer back at 0.
        reset_dut();
        ha = fl(HEAD_FLIT, 32'h10); ba = fl(BODY_FLIT, 32'h11); ta = fl(TAIL_FLIT, 32'h12);
        hc = fl(HEAD_FLIT, 32'h20); tc = fl(TAIL_FLIT, 32'h21);
        hd = fl(HEAD_FLIT, 32'h30); td = fl(TAIL_FLIT, 32'h31);
        cycle(4'b0101, pk(ha, '0, hc, '0), 1'b1, 1'b0);
        chk("t2_rdy1", 64'(last_ready), 64'h1);
        #1; chk("t2_vc1", 64'(vc_id_o), 64'h0);
        cycle(4'b0101, pk(ba, '0, hc, '0), 1'b1, 1'b0);
        chk("t2_rdy2", 64'(last_ready), 64'h1);
        cycle(4'b0101, pk(ta, '0, hc, '0), 1'b1, 1'b0);
        chk("t2_rdy3", 64'(last_ready), 64'h1);
        #1; chk("t2_out_ta", 64'(fdata_o), 64'(ta));
        cycle(4'b0100, pk('0, '0, hc, '0), 1'b1, 1'b0);
        chk("t2_rdy4", 64'(last_ready), 64'h4);
        #1; chk("t2_vc4", 64'(vc_id_o), 64'h2); chk("t2_out_hc", 64'(fdata_o), 64'(hc));
        cycle(4'b0100, pk('0, '0, tc, '0), 1'b1, 1'b0);
        chk("t2_rdy5", 64'(last_ready), 64'h4);
        cycle('0, '0, 1'b1, 1'b0);
        cycle(4'b1001, pk(ha, '0, '0, hd), 1'b1, 1'b0);
        chk("t2_ptr3", 64'(last_ready), 64'h8);
        cycle(4'b1001, pk(ha, '0, '0, td), 1'b1, 1'b0);
        chk("t2_rdy8", 64'(last_ready), 64'h8);
        cycle(4'b0001, pk(ha, '0, '0, '0), 1'b1, 1'b0);
        chk("t2_rdy9", 64'(last_ready), 64'h1);
        cycle(4'b0001, pk(ta, '0, '0, '0), 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);

        // Downstream stall mid-packet.
        cycle(4'b0010, pk('0, h, '0, '0), 1'b1, 1'b0);
        chk("t3_rdy_h", 64'(last_ready), 64'h2);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0010, pk('0, b, '0, '0), 1'b0, 1'b0);
            chk("t3_stall_rdy", 64'(last_ready), 64'h0);
            #1; chk("t3_stall_data", 64'(fdata_o), 64'(h));
        end
        cycle(4'b0010, pk('0, b, '0, '0), 1'b1, 1'b0);
        chk("t3_rdy_b", 64'(last_ready), 64'h2);
        #1; chk("t3_out_b", 64'(fdata_o), 64'(b));
        cycle(4'b0010, pk('0, t, '0, '0), 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);

        // Orphan body on VC3.
        cycle(4'b1000, pk('0, '0, '0, fl(BODY_FLIT, 32'hDEAD)), 1'b1, 1'b0);
        chk("t4_rdy", 64'(last_ready), 64'h8);
        #1; chk("t4_err", 64'(proto_err_o), 64'h1); chk("t4_valid", 64'(valid_o), 64'h0);
        cycle('0, '0, 1'b1, 1'b0);
        #1; chk("t4_err_sticky", 64'(proto_err_o), 64'h1);

        // Reset between head and tail.
        reset_dut();
        cycle(4'b0100, pk('0, '0, hc, '0), 1'b1, 1'b0);
        chk("t5_rdy_h", 64'(last_ready), 64'h4);
        cycle(4'b0100, pk('0, '0, fl(BODY_FLIT, 32'h22), '0), 1'b1, 1'b0);
        cycle(4'b0100, pk('0, '0, fl(BODY_FLIT, 32'h23), '0), 1'b1, 1'b1);
        chk("t5_rdy_rst", 64'(last_ready), 64'h0);
        #1; chk("t5_valid", 64'(valid_o), 64'h0); chk("t5_data", 64'(fdata_o), 64'h0);
        cycle(4'b0010, pk('0, h, '0, '0), 1'b1, 1'b0);
        chk("t5_rdy_new", 64'(last_ready), 64'h2);
        #1; chk("t5_vc_new", 64'(vc_id_o), 64'h1); chk("t5_out_new", 64'(fdata_o), 64'(h));
        cycle(4'b0010, pk('0, t, '0, '0), 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
`else
        // Fixed priority: VC3 beats VC0 every time.
        ha = fl(HEAD_FLIT, 32'h10); ta = fl(TAIL_FLIT, 32'h12);
        hd = fl(HEAD_FLIT, 32'h30); td = fl(TAIL_FLIT, 32'h31);
        for (int i = 0; i < 2; i++) begin
            cycle(4'b1001, pk(ha, '0, '0, hd), 1'b1, 1'b0);
            chk("fp_rdy_h", 64'(last_ready), 64'h8);
            #1; chk("fp_vc", 64'(vc_id_o), 64'h3);
            cycle(4'b1001, pk(ha, '0, '0, td), 1'b1, 1'b0);
            chk("fp_rdy_t", 64'(last_ready), 64'h8);
        end
        cycle(4'b0001, pk(ha, '0, '0, '0), 1'b1, 1'b0);
        chk("fp_rdy_vc0", 64'(last_ready), 64'h1);
        cycle(4'b0001, pk(ta, '0, '0, '0), 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
`endif

        // Randomized traffic on all VCs with random backpressure and rare resets.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            v = '0;
            d = '0;
            for (int k = 0; k < NV; k++) begin
                if (srcq[k].size() == 0) refill(k);
                d[k*FW +: FW] = srcq[k][0];
                v[k] = ($urandom_range(0, 3) != 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            cycle(v, d, rdy, rst);
            for (int k = 0; k < NV; k++)
                if (acc_mask[k]) void'(srcq[k].pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
